uart_fifo: RTL and testbench

Byte-buffering stage between the UART CSR register block and the UART transceiver. It holds a TX FIFO, filled by CSR writes and drained into the transceiver through its `tx_wr`/`tx_done` handshake. It also holds an RX FIFO, filled by transceiver `rx_done` pulses and drained by CSR reads. Software can therefore burst up to `depth` bytes per direction without polling `thre` or losing received bytes between reads.

---
 rtl/uart_sync_fifo.sv | 46 ++++
 rtl/uart_fifo.sv | 127 ++++++++++++
 tb/tb_uart_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers and a show-ahead head.
// push/pop must be pre-qualified by the caller against full/empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic [WIDTH-1:0]      head
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/uart_fifo.sv
// Byte buffering between the UART CSR block and the transceiver:
// TX FIFO drained through a start/done handshake, RX FIFO filled by rx_done.
module uart_fifo #(
    parameter int unsigned depth_log2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  tx_wr,
    input  logic [7:0]            tx_data,
    output logic                  tx_full,
    output logic [depth_log2:0]   tx_level,
    output logic                  tx_overflow,
    output logic                  tx_idle,
    output logic                  xcvr_tx_wr,
    output logic [7:0]            xcvr_tx_data,
    input  logic                  xcvr_tx_done,
    input  logic [7:0]            xcvr_rx_data,
    input  logic                  xcvr_rx_done,
    input  logic                  rx_rd,
    output logic [7:0]            rx_data,
    output logic                  rx_empty,
    output logic [depth_log2:0]   rx_level,
    output logic                  rx_overrun,
    input  logic                  flag_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tx_state_t;

    tx_state_t  state;
    tx_state_t  state_nxt;
    logic       xcvr_tx_wr_nxt;
    logic [7:0] xcvr_tx_data_nxt;

    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_push_c;
    logic       tx_pop_c;
    logic       rx_full;
    logic       rx_push_c;
    logic       rx_pop_c;

    // A write into a full TX FIFO is dropped even if the FSM pops that cycle.
    assign tx_push_c = tx_wr & ~tx_full;
    assign rx_pop_c  = rx_rd & ~rx_empty;
    assign rx_push_c = xcvr_rx_done & (~rx_full | rx_pop_c);

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (depth_log2)
    ) u_tx_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (tx_push_c),
        .push_data (tx_data),
        .pop       (tx_pop_c),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level),
        .head      (tx_head)
    );

    uart_sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (depth_log2)
    ) u_rx_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (rx_push_c),
        .push_data (xcvr_rx_data),
        .pop       (rx_pop_c),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level),
        .head      (rx_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            xcvr_tx_wr   <= 1'b0;
            xcvr_tx_data <= '0;
        end else begin
            state        <= state_nxt;
            xcvr_tx_wr   <= xcvr_tx_wr_nxt;
            xcvr_tx_data <= xcvr_tx_data_nxt;
        end
    end

    // Launch one byte from IDLE, then hold in BUSY until the transceiver reports done.
    always_comb begin
        state_nxt        = state;
        xcvr_tx_wr_nxt   = 1'b0;
        xcvr_tx_data_nxt = xcvr_tx_data;
        tx_pop_c         = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    xcvr_tx_wr_nxt   = 1'b1;
                    xcvr_tx_data_nxt = tx_head;
                    tx_pop_c         = 1'b1;
                    state_nxt        = BUSY;
                end
            end
            BUSY: begin
                if (xcvr_tx_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky error flags; a same-cycle set beats the clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            tx_overflow <= (tx_wr & tx_full) | (tx_overflow & ~flag_clr);
            rx_overrun  <= (xcvr_rx_done & rx_full & ~rx_pop_c) | (rx_overrun & ~flag_clr);
        end
    end

    assign tx_idle = (state == IDLE) & tx_empty & ~xcvr_tx_wr;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo (depth_log2 = 4).
module tb_uart_fifo;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic [4:0] tx_level;
    logic       tx_overflow;
    logic       tx_idle;
    logic       xcvr_tx_wr;
    logic [7:0] xcvr_tx_data;
    logic       xcvr_tx_done;
    logic [7:0] xcvr_rx_data;
    logic       xcvr_rx_done;
    logic       rx_rd;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [4:0] rx_level;
    logic       rx_overrun;
    logic       flag_clr;

    int checks = 0;
    int errors = 0;

    uart_fifo #(.depth_log2(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .tx_level     (tx_level),
        .tx_overflow  (tx_overflow),
        .tx_idle      (tx_idle),
        .xcvr_tx_wr   (xcvr_tx_wr),
        .xcvr_tx_data (xcvr_tx_data),
        .xcvr_tx_done (xcvr_tx_done),
        .xcvr_rx_data (xcvr_rx_data),
        .xcvr_rx_done (xcvr_rx_done),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_level     (rx_level),
        .rx_overrun   (rx_overrun),
        .flag_clr     (flag_clr)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled at the following edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        tx_wr        = 1'b0;
        tx_data      = 8'h00;
        xcvr_tx_done = 1'b0;
        xcvr_rx_data = 8'h00;
        xcvr_rx_done = 1'b0;
        rx_rd        = 1'b0;
        flag_clr     = 1'b0;
        repeat (3) step();
        sys_rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_tx_full",      32'(tx_full),      32'd0);
        chk("rst_tx_level",     32'(tx_level),     32'd0);
        chk("rst_tx_overflow",  32'(tx_overflow),  32'd0);
        chk("rst_tx_idle",      32'(tx_idle),      32'd1);
        chk("rst_xcvr_tx_wr",   32'(xcvr_tx_wr),   32'd0);
        chk("rst_xcvr_tx_data", 32'(xcvr_tx_data), 32'd0);
        chk("rst_rx_data",      32'(rx_data),      32'd0);
        chk("rst_rx_empty",     32'(rx_empty),     32'd1);
        chk("rst_rx_level",     32'(rx_level),     32'd0);
        chk("rst_rx_overrun",   32'(rx_overrun),   32'd0);

        // 1. Single byte
        tx_wr = 1'b1; tx_data = 8'h55;
        step();
        tx_wr = 1'b0;
        chk("t1_level_after_push", 32'(tx_level),   32'd1);
        chk("t1_no_pulse_yet",     32'(xcvr_tx_wr), 32'd0);
        chk("t1_not_idle_queued",  32'(tx_idle),    32'd0);
        step();
        chk("t1_pulse",            32'(xcvr_tx_wr),   32'd1);
        chk("t1_data",             32'(xcvr_tx_data), 32'h55);
        chk("t1_level_popped",     32'(tx_level),     32'd0);
        chk("t1_not_idle_launch",  32'(tx_idle),      32'd0);
        step();
        chk("t1_pulse_one_cycle",  32'(xcvr_tx_wr),   32'd0);
        chk("t1_not_idle_busy",    32'(tx_idle),      32'd0);
        chk("t1_data_held",        32'(xcvr_tx_data), 32'h55);
        xcvr_tx_done = 1'b1;
        step();
        xcvr_tx_done = 1'b0;
        chk("t1_idle_after_done",  32'(tx_idle),      32'd1);

        // 2. TX burst and overflow with the transceiver stalled
        for (int k = 0; k < 18; k++) begin
            tx_wr = 1'b1; tx_data = 8'(k);
            step();
            if (k == 1) begin
                chk("t2_first_pulse", 32'(xcvr_tx_wr),   32'd1);
                chk("t2_first_data",  32'(xcvr_tx_data), 32'h00);
            end
            if (k == 15) chk("t2_not_full_15", 32'(tx_full), 32'd0);
            if (k == 16) begin
                chk("t2_full",        32'(tx_full),     32'd1);
                chk("t2_level_16",    32'(tx_level),    32'd16);
                chk("t2_no_overflow", 32'(tx_overflow), 32'd0);
            end
        end
        tx_wr = 1'b0;
        chk("t2_overflow",        32'(tx_overflow), 32'd1);
        chk("t2_level_after_ovf", 32'(tx_level),    32'd16);
        for (int b = 1; b <= 16; b++) begin
            xcvr_tx_done = 1'b1;
            step();
            xcvr_tx_done = 1'b0;
            chk("t2_gap", 32'(xcvr_tx_wr), 32'd0);
            step();
            chk("t2_drain_pulse", 32'(xcvr_tx_wr),   32'd1);
            chk("t2_drain_data",  32'(xcvr_tx_data), 32'(b));
        end
        xcvr_tx_done = 1'b1;
        step();
        xcvr_tx_done = 1'b0;
        step();
        chk("t2_no_extra_byte", 32'(xcvr_tx_wr),   32'd0);
        chk("t2_last_data",     32'(xcvr_tx_data), 32'h10);
        chk("t2_idle_end",      32'(tx_idle),      32'd1);
        chk("t2_ovf_sticky",    32'(tx_overflow),  32'd1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("t2_ovf_cleared",   32'(tx_overflow),  32'd0);

        // 3. RX fill and overrun
        for (int k = 0; k < 17; k++) begin
            xcvr_rx_done = 1'b1; xcvr_rx_data = 8'(8'hA0 + k);
            step();
            if (k == 0) begin
                chk("t3_head_first", 32'(rx_data),  32'hA0);
                chk("t3_not_empty",  32'(rx_empty), 32'd0);
            end
            if (k == 15) chk("t3_no_overrun_yet", 32'(rx_overrun), 32'd0);
        end
        xcvr_rx_done = 1'b0;
        chk("t3_level_16", 32'(rx_level),   32'd16);
        chk("t3_overrun",  32'(rx_overrun), 32'd1);
        rx_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_read", 32'(rx_data), 32'(8'hA0 + i));
            step();
        end
        rx_rd = 1'b0;
        chk("t3_empty",       32'(rx_empty), 32'd1);
        chk("t3_level_0",     32'(rx_level), 32'd0);
        chk("t3_data_masked", 32'(rx_data),  32'd0);
        rx_rd = 1'b1;
        step();
        rx_rd = 1'b0;
        chk("t3_rd_empty_ignored", 32'(rx_level), 32'd0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("t3_overrun_cleared", 32'(rx_overrun), 32'd0);

        // 4. Simultaneous push and pop on a full RX FIFO
        for (int k = 0; k < 16; k++) begin
            xcvr_rx_done = 1'b1; xcvr_rx_data = 8'(8'h10 + k);
            step();
        end
        chk("t4_full_level", 32'(rx_level), 32'd16);
        rx_rd = 1'b1; xcvr_rx_data = 8'h7E;
        step();
        xcvr_rx_done = 1'b0; rx_rd = 1'b0;
        chk("t4_level_stays", 32'(rx_level),   32'd16);
        chk("t4_no_overrun",  32'(rx_overrun), 32'd0);
        chk("t4_new_head",    32'(rx_data),    32'h11);
        rx_rd = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("t4_last_is_7e", 32'(rx_data),  32'h7E);
        chk("t4_level_1",    32'(rx_level), 32'd1);
        step();
        rx_rd = 1'b0;
        chk("t4_empty", 32'(rx_empty), 32'd1);

        // 5. Flag clear versus set in the same cycle
        for (int k = 0; k < 16; k++) begin
            xcvr_rx_done = 1'b1; xcvr_rx_data = 8'(8'h20 + k);
            step();
        end
        chk("t5_no_overrun_before", 32'(rx_overrun), 32'd0);
        xcvr_rx_data = 8'hEE; flag_clr = 1'b1;
        step();
        xcvr_rx_done = 1'b0; flag_clr = 1'b0;
        chk("t5_set_wins",  32'(rx_overrun), 32'd1);
        chk("t5_head_kept", 32'(rx_data),    32'h20);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("t5_cleared",   32'(rx_overrun), 32'd0);

        // 6. Reset in BUSY with 3 bytes queued
        for (int k = 0; k < 5; k++) begin
            tx_wr = 1'b1; tx_data = 8'(8'hC0 + k);
            step();
        end
        tx_wr = 1'b0;
        chk("t6_level_4", 32'(tx_level), 32'd4);
        xcvr_tx_done = 1'b1;
        step();
        xcvr_tx_done = 1'b0;
        step();
        chk("t6_pulse_before_rst", 32'(xcvr_tx_wr),   32'd1);
        chk("t6_data_before_rst",  32'(xcvr_tx_data), 32'hC1);
        chk("t6_level_3",          32'(tx_level),     32'd3);
        sys_rst_n = 1'b0;
        #1;
        chk("t6_rst_tx_level",  32'(tx_level),   32'd0);
        chk("t6_rst_tx_idle",   32'(tx_idle),    32'd1);
        chk("t6_rst_tx_wr",     32'(xcvr_tx_wr), 32'd0);
        chk("t6_rst_rx_level",  32'(rx_level),   32'd0);
        chk("t6_rst_rx_empty",  32'(rx_empty),   32'd1);
        chk("t6_rst_rx_ovr",    32'(rx_overrun), 32'd0);
        #2;
        sys_rst_n = 1'b1;
        step();
        xcvr_tx_done = 1'b1;
        step();
        xcvr_tx_done = 1'b0;
        chk("t6_stray_done_no_pulse_a", 32'(xcvr_tx_wr), 32'd0);
        step();
        chk("t6_stray_done_no_pulse_b", 32'(xcvr_tx_wr), 32'd0);
        chk("t6_idle_after",            32'(tx_idle),    32'd1);
        chk("t6_level_after",           32'(tx_level),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
